// File: rtl/hazard_unit_pkg.sv
// Shared constants and forwarding-select helper for the pipeline hazard unit.
`default_nettype none

package hazard_unit_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [3:0] REG_PC  = 4'd15;

   // Memory stage wins over writeback; the PC is never forwarded.
   function automatic logic [1:0] fwdSel(
      input logic [3:0] srcE,
      input logic [3:0] wa3M,
      input logic [3:0] wa3W,
      input logic       regWriteM,
      input logic       regWriteW,
      input logic       ignoreSrc
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (srcE != REG_PC && !ignoreSrc) begin
         if (regWriteM && wa3M == srcE)
            sel = FWD_MEM;
         else if (regWriteW && wa3W == srcE)
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
// +----------------------------------------------------------------+
// | sat_counter : enable-driven event counter, saturates at max    |
// | rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (en && count != {WIDTH{1'b1}})
         count <= count + 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// +----------------------------------------------------------------+
// | hazard_unit : stall/flush/forward generation with event counts |
// | rev 1.0                                                        |
// +----------------------------------------------------------------+
`default_nettype none

module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       RA1D,
   input  logic [3:0]       RA2D,
   input  logic [3:0]       WA3D,
   input  logic             IgRnE,
   input  logic             MemtoRegE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             PCSrcD,
   input  logic             PCSrcE,
   input  logic             PCSrcM,
   input  logic             PCSrcW,
   input  logic             BranchTakenE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   logic [3:0] r_RA1E, r_RA2E, r_WA3E, r_WA3M, r_WA3W;
   logic       w_ldrStall;
   logic       w_pcWrPendingF;

   // Register numbers follow the instruction; E/M/W never stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_RA1E <= '0;
         r_RA2E <= '0;
         r_WA3E <= '0;
         r_WA3M <= '0;
         r_WA3W <= '0;
      end else begin
         if (FlushE) begin
            r_RA1E <= '0;
            r_RA2E <= '0;
            r_WA3E <= '0;
         end else begin
            r_RA1E <= RA1D;
            r_RA2E <= RA2D;
            r_WA3E <= WA3D;
         end
         r_WA3M <= r_WA3E;
         r_WA3W <= r_WA3M;
      end
   end

   always_comb begin
      ForwardAE      = fwdSel(r_RA1E, r_WA3M, r_WA3W, RegWriteM, RegWriteW, IgRnE);
      ForwardBE      = fwdSel(r_RA2E, r_WA3M, r_WA3W, RegWriteM, RegWriteW, 1'b0);
      w_ldrStall     = MemtoRegE && (RA1D == r_WA3E || RA2D == r_WA3E);
      w_pcWrPendingF = PCSrcD | PCSrcE | PCSrcM;
      StallF         = w_ldrStall | w_pcWrPendingF;
      StallD         = w_ldrStall;
      FlushD         = w_pcWrPendingF | PCSrcW | BranchTakenE;
      FlushE         = w_ldrStall | BranchTakenE;
   end

   sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
      .clk   (clk),
      .reset (reset),
      .en    (StallF),
      .count (StallCount)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
      .clk   (clk),
      .reset (reset),
      .en    (FlushE),
      .count (FlushCount)
   );

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// Directed plus randomized bench for hazard_unit against an instruction-record pipeline model.
`default_nettype none

module tb_hazard_unit;

   logic clk = 1'b0;
   logic reset;
   logic [3:0] RA1D, RA2D, WA3D;
   logic IgRnE, MemtoRegE, RegWriteM, RegWriteW;
   logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   logic [1:0] ForwardAE, ForwardBE, sFwdA, sFwdB;
   logic StallF, StallD, FlushD, FlushE, sStallF, sStallD, sFlushD, sFlushE;
   logic [15:0] StallCount, FlushCount;
   logic [3:0]  sStallCount, sFlushCount;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hazard_unit #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
      .IgRnE(IgRnE), .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   hazard_unit #(.CNT_W(4)) dutSmall (
      .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
      .IgRnE(IgRnE), .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE), .ForwardAE(sFwdA), .ForwardBE(sFwdB),
      .StallF(sStallF), .StallD(sStallD), .FlushD(sFlushD), .FlushE(sFlushE),
      .StallCount(sStallCount), .FlushCount(sFlushCount)
   );

   // Reference model: one record per in-flight instruction, index 0=E, 1=M, 2=W.
   typedef struct {
      logic [3:0] ra1;
      logic [3:0] ra2;
      logic [3:0] wa3;
   } instr_t;

   instr_t pipe [3];
   int     mStall, mFlush;
   logic   eStallF, eStallD, eFlushD, eFlushE, eLdr;
   logic [1:0] eFwdA, eFwdB;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] refFwd(input logic [3:0] src, input logic ign);
      if (src == 4'd15 || ign) return 2'b00;
      if (RegWriteM && pipe[1].wa3 == src) return 2'b10;
      if (RegWriteW && pipe[2].wa3 == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 3; i++) pipe[i] = '{4'd0, 4'd0, 4'd0};
      mStall = 0;
      mFlush = 0;
   endtask

   task automatic clearIns();
      RA1D = 0; RA2D = 0; WA3D = 0;
      IgRnE = 0; MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0;
      PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
   endtask

   // Let combinational outputs settle mid-cycle, then compare everything to the model.
   task automatic settle();
      #1;
      eLdr    = MemtoRegE && (RA1D == pipe[0].wa3 || RA2D == pipe[0].wa3);
      eStallF = eLdr | PCSrcD | PCSrcE | PCSrcM;
      eStallD = eLdr;
      eFlushD = PCSrcD | PCSrcE | PCSrcM | PCSrcW | BranchTakenE;
      eFlushE = eLdr | BranchTakenE;
      eFwdA   = refFwd(pipe[0].ra1, IgRnE);
      eFwdB   = refFwd(pipe[0].ra2, 1'b0);
      chk("ForwardAE", 16'(ForwardAE), 16'(eFwdA));
      chk("ForwardBE", 16'(ForwardBE), 16'(eFwdB));
      chk("StallF", 16'(StallF), 16'(eStallF));
      chk("StallD", 16'(StallD), 16'(eStallD));
      chk("FlushD", 16'(FlushD), 16'(eFlushD));
      chk("FlushE", 16'(FlushE), 16'(eFlushE));
      chk("StallCount", StallCount, 16'(sat(mStall, 65535)));
      chk("FlushCount", FlushCount, 16'(sat(mFlush, 65535)));
      chk("StallCount4", 16'(sStallCount), 16'(sat(mStall, 15)));
      chk("FlushCount4", 16'(sFlushCount), 16'(sat(mFlush, 15)));
   endtask

   task automatic tick();
      instr_t nE;
      nE = eFlushE ? '{4'd0, 4'd0, 4'd0} : '{RA1D, RA2D, WA3D};
      @(posedge clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nE;
      if (eStallF) mStall++;
      if (eFlushE) mFlush++;
      #1;
   endtask

   function automatic logic [3:0] rndReg();
      int v;
      v = $urandom_range(0, 4);
      return (v == 4) ? 4'd15 : 4'(v);
   endfunction

   int baseStall, baseFlush;

   initial begin
      reset = 1'b1;
      clearIns();
      modelReset();
      #2;
      settle();
      #4 reset = 1'b0;
      @(posedge clk);
      #1;

      // Five PC-write stall cycles, then an asynchronous reset mid-cycle.
      PCSrcD = 1;
      for (int i = 0; i < 5; i++) begin
         settle();
         tick();
      end
      clearIns();
      settle();
      chk("StallCount_before_reset", StallCount, 16'd5);
      reset = 1'b1;
      modelReset();
      #1;
      chk("rst_StallCount", StallCount, 16'd0);
      chk("rst_FlushCount", FlushCount, 16'd0);
      chk("rst_WA3E", 16'(dut.r_WA3E), 16'd0);
      chk("rst_WA3M", 16'(dut.r_WA3M), 16'd0);
      chk("rst_WA3W", 16'(dut.r_WA3W), 16'd0);
      reset = 1'b0;
      settle();
      tick();

      // ADD r3 ; SUB r4,r3 -> memory then writeback forwarding.
      WA3D = 3; settle(); tick();
      RA1D = 3; WA3D = 4; settle(); tick();
      RegWriteM = 1; settle();
      chk("fwd_mem_A", 16'(ForwardAE), 16'b10);
      tick();
      RegWriteM = 0; RegWriteW = 1; settle();
      chk("fwd_wb_A", 16'(ForwardAE), 16'b01);
      tick();
      clearIns(); settle(); tick();

      // LDR r2 ; ADD using r2 -> one-cycle load-use stall.
      WA3D = 2; settle(); tick();
      baseStall = mStall;
      WA3D = 6; RA2D = 2; MemtoRegE = 1; settle();
      chk("ldr_StallF", 16'(StallF), 16'd1);
      chk("ldr_StallD", 16'(StallD), 16'd1);
      chk("ldr_FlushE", 16'(FlushE), 16'd1);
      tick();
      MemtoRegE = 0; settle();
      chk("ldr_StallF_after", 16'(StallF), 16'd0);
      chk("ldr_StallCount", StallCount, 16'(baseStall + 1));
      tick();
      RegWriteW = 1; settle();
      chk("ldr_fwd_wb_B", 16'(ForwardBE), 16'b01);
      tick();
      clearIns(); settle(); tick();

      // PC write walking D->E->M->W.
      baseStall = mStall;
      for (int s = 0; s < 4; s++) begin
         clearIns();
         PCSrcD = (s == 0); PCSrcE = (s == 1); PCSrcM = (s == 2); PCSrcW = (s == 3);
         settle();
         chk("pc_StallF", 16'(StallF), (s < 3) ? 16'd1 : 16'd0);
         chk("pc_FlushD", 16'(FlushD), 16'd1);
         tick();
      end
      clearIns(); settle();
      chk("pc_StallCount", StallCount, 16'(baseStall + 3));
      tick();

      // Taken branch coinciding with a load-use match.
      WA3D = 5; settle(); tick();
      baseFlush = mFlush;
      WA3D = 0; RA1D = 5; MemtoRegE = 1; BranchTakenE = 1; settle();
      chk("br_FlushD", 16'(FlushD), 16'd1);
      chk("br_FlushE", 16'(FlushE), 16'd1);
      chk("br_StallD", 16'(StallD), 16'd1);
      tick();
      clearIns(); settle();
      chk("br_FlushCount", FlushCount, 16'(baseFlush + 1));
      tick();

      // PC register is never forwarded.
      WA3D = 15; settle(); tick();
      RA1D = 15; WA3D = 0; settle(); tick();
      RA1D = 0; RegWriteM = 1; settle();
      chk("r15_nofwd_A", 16'(ForwardAE), 16'b00);
      tick();
      clearIns();

      // Twenty stall cycles saturate the 4-bit counter.
      PCSrcD = 1;
      for (int i = 0; i < 20; i++) begin
         settle();
         tick();
      end
      clearIns(); settle();
      chk("sat_StallCount4", 16'(sStallCount), 16'd15);
      tick();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         RA1D = rndReg(); RA2D = rndReg(); WA3D = rndReg();
         IgRnE        = ($urandom_range(0, 3) == 0);
         MemtoRegE    = ($urandom_range(0, 2) == 0);
         RegWriteM    = $urandom_range(0, 1) != 0;
         RegWriteW    = $urandom_range(0, 1) != 0;
         PCSrcD       = ($urandom_range(0, 5) == 0);
         PCSrcE       = ($urandom_range(0, 5) == 0);
         PCSrcM       = ($urandom_range(0, 5) == 0);
         PCSrcW       = ($urandom_range(0, 5) == 0);
         BranchTakenE = ($urandom_range(0, 7) == 0);
         settle();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer of the pipeline controller's stage-tagged control bits (RegWriteM/W, MemtoRegE, PCSrcD/E/M/W, BranchTakenE, IgRnE).
- Producer of the stall, flush and forward signals the controller and datapath consume; FlushE goes back into the controller's D->E register.
- Tracks source and destination register numbers through E/M/W internally, so the datapath only supplies decode-stage register addresses.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- RA1D  input  4  decode-stage first source register (Rn).
- RA2D  input  4  decode-stage second source register (Rm/Rd).
- WA3D  input  4  decode-stage destination register.
- IgRnE  input  1  execute instruction ignores Rn (e.g. MOV).
- MemtoRegE  input  1  execute instruction is a load.
- RegWriteM  input  1  memory-stage instruction writes the register file.
- RegWriteW  input  1  writeback-stage instruction writes the register file.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  input  1 each  instruction in that stage writes PC.
- BranchTakenE  input  1  branch resolved taken in execute.
- ForwardAE  output  2  SrcA mux select: 00 register file, 01 ResultW, 10 ALUOutM.
- ForwardBE  output  2  SrcB mux select, same encoding.
- StallF  output  1  hold PC.
- StallD  output  1  hold F->D register.
- FlushD  output  1  clear F->D register.
- FlushE  output  1  clear D->E register (controller and datapath).
- StallCount  output  CNT_W  cycles with StallF=1.
- FlushCount  output  CNT_W  cycles with FlushE=1.

Behaviour:
- Internal registers: RA1E, RA2E, WA3E, WA3M, WA3W (4 bits each); StallCount and FlushCount.
- Reset (async, active-high): all internal registers and both counters go to 0 immediately. All other outputs are combinational and follow the inputs, so they are 0 when every control input is 0.
- Each rising edge:
  - If FlushE: RA1E/RA2E/WA3E <= 0. Otherwise: RA1E<=RA1D, RA2E<=RA2D, WA3E<=WA3D.
  - WA3M<=WA3E; WA3W<=WA3M (the E/M/W stages never stall).
- Forwarding (combinational, A path; B path identical using RA2E with no IgRnE term):
  - ForwardAE=10 if RegWriteM & WA3M==RA1E & RA1E!=15 & !IgRnE.
  - Else ForwardAE=01 if RegWriteW & WA3W==RA1E & RA1E!=15 & !IgRnE.
  - Else 00.
  - Memory stage has priority over writeback when both match.
  - R15 is never forwarded.
- Load-use: LDRstall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E).
- PC-write pending: PCWrPendingF = PCSrcD | PCSrcE | PCSrcM.
- Control outputs:
  - StallF = LDRstall | PCWrPendingF.
  - StallD = LDRstall.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
- Simultaneous events:
  - LDRstall with BranchTakenE: FlushE=1 and StallD=1. The branch wins because FlushD=1 also discards D.
  - StallD and FlushD both 1: the F->D register applies its clear (clear has priority, as in the datapath's enable/clear registers).
- Counters: increment by 1 on each edge where the monitored signal is 1. They saturate at 2^CNT_W-1 and never wrap.
- Reset asserted mid-stall: internal state clears at once. After release the first cycle sees WA3E=0, so a pending load-use match on R0 is not re-raised unless MemtoRegE is still 1.

Decomposition:
- Shared package holds:
  - forwarding-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - PC register index constant REG_PC=4'd15.
- One sub-module, sat_counter (parameterised width, async reset, enable). Instantiated twice for StallCount and FlushCount.

Test Plan:
- Reset pulse mid-run with StallCount=5 -> StallCount, FlushCount, WA3E/M/W read 0 immediately, before any clock edge.
- ADD r3 then SUB r4,r3 (WA3D=3, then RA1D=3), RegWriteM=1 after one edge -> ForwardAE=10. One edge later with RegWriteW=1 and RegWriteM=0 -> ForwardAE=01.
- LDR r2 then ADD using r2 (MemtoRegE=1, WA3E=2, RA2D=2) -> StallF=1, StallD=1, FlushE=1 for exactly one cycle; StallCount +1; next cycle ForwardBE=01 once the load reaches writeback.
- PCSrcD=1 propagating D->E->M->W -> StallF=1 and FlushD=1 for 3 cycles, then FlushD=1 alone for 1 cycle; StallCount +3.
- BranchTakenE=1 together with a load-use match -> FlushD=1, FlushE=1, StallD=1; FlushCount +1.
- RA1E=15 with WA3M=15 and RegWriteM=1 -> ForwardAE=00. Separately, CNT_W=4 with 20 stall cycles -> StallCount stays at 15.
